// File: rtl/rc4_pkg.sv
// rc4_pkg: shared widths and PRGA state encoding for the RC4 decryptor
package rc4_pkg;
    localparam int BYTE_W  = 8;
    localparam int S_DEPTH = 256;
    localparam int S_AW    = $clog2(S_DEPTH);
    typedef enum logic [3:0] {IDLE, RD_LEN, LEN, RDI, RDJ, WRI, WRJ, RDP, WRPT} prga_state_t;
endpackage

// File: rtl/prga.sv
// prga: RC4 keystream stage, swaps S in place and writes pt[k] = ct[k] ^ pad
module prga
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [S_AW-1:0]   s_addr,
    input  logic [BYTE_W-1:0] s_rddata,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [S_AW-1:0]   ct_addr,
    input  logic [BYTE_W-1:0] ct_rddata,
    output logic [S_AW-1:0]   pt_addr,
    output logic [BYTE_W-1:0] pt_wrdata,
    output logic              pt_wren
);
    prga_state_t state_q, state_d;
    logic [BYTE_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [BYTE_W-1:0] si_q, si_d, sj_q, sj_d, ctb_q, ctb_d;

    // Sequencing: one S access per state, six states per payload byte
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        len_d   = len_q;
        si_d    = si_q;
        sj_d    = sj_q;
        ctb_d   = ctb_q;
        case (state_q)
            IDLE: if (en) begin
                i_d     = '0;
                j_d     = '0;
                k_d     = 8'd1;
                state_d = RD_LEN;
            end
            RD_LEN: state_d = LEN;
            LEN: begin
                len_d   = ct_rddata;
                state_d = (ct_rddata == '0) ? IDLE : RDI;
            end
            RDI: begin
                i_d     = i_q + 1'b1;
                state_d = RDJ;
            end
            RDJ: begin
                si_d    = s_rddata;
                ctb_d   = ct_rddata;
                j_d     = j_q + s_rddata;
                state_d = WRI;
            end
            WRI: begin
                sj_d    = s_rddata;
                state_d = WRJ;
            end
            WRJ: state_d = RDP;
            RDP: state_d = WRPT;
            WRPT: begin
                k_d     = k_q + 1'b1;
                state_d = (k_q == len_q) ? IDLE : RDI;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            ctb_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            ctb_q   <= ctb_d;
        end
    end

    assign rdy       = state_q == IDLE;
    assign s_addr    = (state_q == RDI) ? i_q + 1'b1 :
                       (state_q == RDJ) ? j_q + s_rddata :
                       (state_q == WRI) ? i_q :
                       (state_q == WRJ) ? j_q :
                       (state_q == RDP) ? si_q + sj_q : '0;
    assign s_wrdata  = (state_q == WRI) ? s_rddata : (state_q == WRJ) ? si_q : '0;
    assign s_wren    = (state_q == WRI) || (state_q == WRJ);
    assign ct_addr   = (state_q == RDI) ? k_q : '0;
    assign pt_addr   = (state_q == WRPT) ? k_q : '0;
    assign pt_wrdata = (state_q == LEN) ? ct_rddata : (state_q == WRPT) ? (s_rddata ^ ctb_q) : '0;
    assign pt_wren   = (state_q == LEN) || (state_q == WRPT);
endmodule

// File: tb/tb_prga.sv
// tb_prga: memory models, RC4 reference scoreboard and directed/table tests for prga
module tb_prga;
    logic clk, rst, en, rdy, s_wren, pt_wren;
    logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_img [256];
    logic [7:0] ct_img [256];
    logic [7:0] ref_s [256];
    logic [15:0] sb [$];
    logic [15:0] s_log [$];
    int n_chk, n_pass, s_wr_cnt, wr_cnt;
    bit sb_on;

    typedef struct {
        string nm;
        int    len;
        bit    ident;
        int    exp_lat;
    } vec_t;
    vec_t vecs [4];

    prga dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    always @(negedge clk) begin
        if (s_wren) begin
            s_wr_cnt++;
            s_log.push_back({s_addr, s_wrdata});
        end
        if (s_wren || pt_wren) wr_cnt++;
        if (sb_on && pt_wren) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL pt_unexpected: got write %0h=%0h expected none", pt_addr, pt_wrdata);
            end else chk("pt_write", {pt_addr, pt_wrdata}, sb.pop_front());
        end
    end

    task automatic load(input bit ident, input int len);
        int b;
        logic [7:0] t;
        for (int a = 0; a < 256; a++) begin
            s_img[a]  = a[7:0];
            ct_img[a] = 8'($urandom_range(0, 255));
        end
        if (!ident)
            for (int a = 255; a > 0; a--) begin
                b = $urandom_range(0, a);
                t = s_img[a];
                s_img[a] = s_img[b];
                s_img[b] = t;
            end
        ct_img[0] = len[7:0];
        for (int a = 0; a < 256; a++) begin
            s_mem[a]  <= s_img[a];
            ct_mem[a] <= ct_img[a];
            pt_mem[a] <= 8'hee;
        end
        ref_s = s_img;
        @(posedge clk);
        #1;
    endtask

    task automatic ref_run();
        logic [7:0] i, j, t, idx;
        int l;
        i = 0;
        j = 0;
        l = ct_img[0];
        sb.push_back({8'd0, ct_img[0]});
        for (int k = 1; k <= l; k++) begin
            i = i + 8'd1;
            j = j + ref_s[i];
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
            idx = ref_s[i] + ref_s[j];
            sb.push_back({k[7:0], ct_img[k] ^ ref_s[idx]});
        end
    endtask

    function automatic int s_mismatch();
        int n = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== ref_s[a]) n++;
        return n;
    endfunction

    task automatic run(input string nm, input int exp_lat, input bit pulse);
        int cyc;
        bit was_rdi;
        cyc = 0;
        was_rdi = 0;
        s_wr_cnt = 0;
        s_log.delete();
        en = 1;
        @(posedge clk);
        #1;
        en = 0;
        while (!rdy && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            en = pulse && was_rdi;
            was_rdi = ct_addr != 0;
        end
        en = 0;
        chk({nm, "_lat"}, cyc, exp_lat);
        chk({nm, "_sb_drain"}, sb.size(), 0);
    endtask

    initial begin
        int cyc;
        n_chk = 0;
        n_pass = 0;
        sb_on = 1;
        rst = 1;
        en = 0;
        vecs[0] = '{"len1", 1, 1'b1, 8};
        vecs[1] = '{"len5", 5, 1'b0, 32};
        vecs[2] = '{"len17", 17, 1'b0, 104};
        vecs[3] = '{"len255", 255, 1'b0, 1532};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", rdy, 1);
        chk("rst_wren", {s_wren, pt_wren}, 0);
        chk("rst_addr", {s_addr, ct_addr, pt_addr}, 0);
        chk("rst_wdata", {s_wrdata, pt_wrdata}, 0);
        rst = 0;
        @(posedge clk);
        #1;
        load(1, 2);
        ct_img[1] = 8'h43;
        ct_img[2] = 8'h47;
        ct_mem[1] <= 8'h43;
        ct_mem[2] <= 8'h47;
        @(posedge clk);
        #1;
        ref_run();
        run("ident2", 14, 0);
        chk("ident2_pt0", pt_mem[0], 8'h02);
        chk("ident2_pt1", pt_mem[1], 8'h41);
        chk("ident2_pt2", pt_mem[2], 8'h42);
        chk("ident2_pad1", pt_mem[1] ^ 8'h43, 8'h02);
        chk("ident2_s2", s_mem[2], 8'h03);
        chk("ident2_s3", s_mem[3], 8'h02);
        chk("ident2_s_rest", s_mismatch(), 0);
        chk("ident2_swr0", s_log.size() > 0 ? s_log[0] : 16'hxxxx, 16'h0101);
        chk("ident2_swr1", s_log.size() > 1 ? s_log[1] : 16'hxxxx, 16'h0101);
        chk("ident2_swr_cnt", s_wr_cnt, 4);
        load(1, 0);
        ref_run();
        run("len0", 2, 0);
        chk("len0_pt0", pt_mem[0], 8'h00);
        chk("len0_no_swr", s_wr_cnt, 0);
        foreach (vecs[v]) begin
            load(vecs[v].ident, vecs[v].len);
            ref_run();
            run(vecs[v].nm, vecs[v].exp_lat, 0);
            chk({vecs[v].nm, "_final_s"}, s_mismatch(), 0);
        end
        load(0, 4);
        ref_run();
        run("en_rdj", 26, 1);
        chk("en_rdj_final_s", s_mismatch(), 0);
        load(0, 3);
        sb_on = 0;
        cyc = 0;
        en = 1;
        @(posedge clk);
        #1;
        en = 0;
        while (!s_wren && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst_wri_reached", s_wren, 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("rst_mid_rdy", rdy, 1);
        chk("rst_mid_wren", {s_wren, pt_wren}, 0);
        wr_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_quiet", wr_cnt, 0);
        sb.delete();
        sb_on = 1;
        load(1, 2);
        ct_img[1] = 8'h43;
        ct_img[2] = 8'h47;
        ct_mem[1] <= 8'h43;
        ct_mem[2] <= 8'h47;
        @(posedge clk);
        #1;
        ref_run();
        ref_run();
        cyc = 0;
        en = 1;
        @(posedge clk);
        #1;
        while (!rdy && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b_lat1", cyc, 14);
        @(posedge clk);
        #1;
        en = 0;
        chk("b2b_restart", rdy, 0);
        cyc = 0;
        while (!rdy && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b_lat2", cyc, 14);
        chk("b2b_sb_drain", sb.size(), 0);
        chk("b2b_final_s", s_mismatch(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
